// File: rtl/data_ram_resp.sv
// data_ram_resp: wait-stated word RAM answering mem_* load/store requests with byte-lane masked writes
module data_ram_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic we_q;
  logic [31:2] addr_q;
  logic [3:0] sel_q;
  logic [31:0] data_q;
  logic [31:0] ram [0:(1<<ADDR_WIDTH)-1];
  logic oor;
  logic [ADDR_WIDTH-1:0] idx;
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_addr[1:0]};
  assign oor = |addr_q[31:ADDR_WIDTH+2];
  assign idx = addr_q[ADDR_WIDTH+1:2];
  always_comb begin
    next = state;
    next = state == IDLE ? (mem_ce ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
           state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  // The access itself happens on the edge leaving RESP, so its results are registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      mem_data_o <= '0;
      mem_ready  <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      state     <= next;
      mem_ready <= state == RESP;
      mem_err   <= state == RESP && oor;
      if (state == IDLE && mem_ce) begin
        we_q   <= mem_we;
        addr_q <= mem_addr[31:2];
        sel_q  <= mem_sel;
        data_q <= mem_data_i;
        cnt    <= 4'(WAIT_CYCLES);
      end else if (state == WAIT)
        cnt <= cnt - 4'd1;
      if (state == RESP && !we_q)
        mem_data_o <= oor ? 32'h0 : ram[idx];
    end
  end
  always_ff @(posedge clk) begin
    if (state == RESP && we_q && !oor)
      for (int i = 0; i < 4; i++)
        if (sel_q[i]) ram[idx][8*i +: 8] <= data_q[8*i +: 8];
  end
endmodule
